envelope_shaper: RTL and testbench
==================================

Name: envelope_shaper

Overview:
- ADSR amplitude envelope stage between the sine generator and the two PWM DACs of the tone player.
- Scales the sine generator's positive and negative half-wave samples by an 8-bit envelope level before they drive the DAC t_on inputs.
- The player drives gate high for each tone, optionally drops it briefly between tones, and raises it again at the next tone.
- The envelope level steps once per sample strobe, which is the 8 kHz fs tick from the fs clkgen.

Parameters:
- W, 9, sample width of the pos/neg inputs and outputs; matches the pitch/DAC width.
- ATTACK_STEP, 8, envelope increment per fs_tick in ATTACK; range 1..255.
- DECAY_STEP, 2, envelope decrement per fs_tick in DECAY; range 1..255.
- SUSTAIN_LEVEL, 192, level held in SUSTAIN; range 0..255.
- RELEASE_STEP, 4, envelope decrement per fs_tick in RELEASE; range 1..255.

Ports:
- clk  in  1  system clock (10 MHz).
- reset  in  1  synchronous, active-high.
- fs_tick  in  1  one-clk-wide sample strobe; envelope steps only on cycles where this is high.
- gate  in  1  note gate; a rising edge starts or retriggers the note, a falling edge releases it.
- pos_in  in  W  positive half-wave sample from the sine generator.
- neg_in  in  W  negative half-wave sample from the sine generator.
- pos_out  out  W  scaled positive sample, to the pos DAC t_on.
- neg_out  out  W  scaled negative sample, to the neg DAC t_on.
- level  out  8  current envelope level.
- state  out  3  envelope state: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Reset: state=IDLE, level=0, pos_out=0, neg_out=0, busy=0, internal gate_q=0.
  - Reset mid-note aborts immediately; there is no release tail.
  - If gate is high at reset release, a rise is detected on the first cycle after reset.
- Edge detect, every clk:
  - rise = gate & ~gate_q
  - fall = ~gate & gate_q
  - gate_q <= gate
- Priority per cycle: reset > rise > fall > fs_tick step.
- rise, in any state: state <= ATTACK.
  - level is unchanged, so a retrigger attacks from the current level with no click to 0.
- fall, in ATTACK, DECAY or SUSTAIN: state <= RELEASE, level unchanged.
  - fall in IDLE or RELEASE: no effect.
- On a cycle with an edge, any coincident fs_tick is ignored (no step that cycle).
- fs_tick step, no edge present:
  - IDLE: level stays 0.
  - ATTACK: if level > 255-ATTACK_STEP, then level <= 255 and state <= DECAY; else level += ATTACK_STEP.
  - DECAY: if level-DECAY_STEP <= SUSTAIN_LEVEL (signed compare, no underflow), then level <= SUSTAIN_LEVEL and state <= SUSTAIN; else level -= DECAY_STEP.
  - SUSTAIN: level holds at SUSTAIN_LEVEL.
  - RELEASE: if level <= RELEASE_STEP, then level <= 0 and state <= IDLE; else level -= RELEASE_STEP.
- All level arithmetic saturates; level never wraps.
- Scaling: registered, 1 clk latency from pos_in/neg_in/level to outputs.
  - x_out <= (level==255) ? x_in : (x_in*level)>>8, computed with a W+8-bit product and truncated.
  - Full scale passes through exactly; level 0 gives 0.
- busy and state are combinational from the state register. level is the register itself.
- Outputs update every clk, not only on fs_tick; the sine input may change at any clk.

Test Plan:
- Reset with gate=0 and pos_in=300 -> state=0, level=0, pos_out=0 and neg_out=0 on every cycle; 100 fs_ticks keep level=0.
- Attack: raise gate, then apply fs_ticks -> state=1 and level=8k after k ticks; tick 32 gives level=255 and state=2.
- Decay: continue ticking -> level=255-2k; at tick 32 of decay level=192 and state=3; further ticks hold 192.
- Scaling: in SUSTAIN with pos_in=300 and neg_in=0 -> pos_out=225, neg_out=0 one clk after the input changes; at level 255, pos_in=511 gives pos_out=511.
- Release: drop gate in SUSTAIN -> state=4 next clk; level 192-4k; tick 48 gives level=0, state=0, busy=0.
- Retrigger and edge cases:
  - Raise gate during RELEASE at level 100 -> state=1 and level stays 100 that cycle.
  - The next tick gives level=108.
  - An fs_tick coincident with the rise produces no step.
  - Asserting reset mid-ATTACK gives level=0 and state=0 on the next clk.

Source files
------------

// File: rtl/envelope_shaper.sv
// ADSR amplitude envelope between the sine generator and the PWM DACs.
// Level steps on fs_tick; the sine halves are scaled by level with 1 clk latency.
module envelope_shaper #(
    parameter int W             = 9,
    parameter int ATTACK_STEP   = 8,
    parameter int DECAY_STEP    = 2,
    parameter int SUSTAIN_LEVEL = 192,
    parameter int RELEASE_STEP  = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         fs_tick,
    input  logic         gate,
    input  logic [W-1:0] pos_in,
    input  logic [W-1:0] neg_in,
    output logic [W-1:0] pos_out,
    output logic [W-1:0] neg_out,
    output logic [7:0]   level,
    output logic [2:0]   state,
    output logic         busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } env_state_t;

    localparam int PW = W + 8;

    localparam logic [7:0] A_STEP  = 8'(ATTACK_STEP);
    localparam logic [7:0] D_STEP  = 8'(DECAY_STEP);
    localparam logic [7:0] R_STEP  = 8'(RELEASE_STEP);
    localparam logic [7:0] S_LEVEL = 8'(SUSTAIN_LEVEL);
    localparam logic [7:0] A_LIMIT = 8'(255 - ATTACK_STEP);
    // level - D_STEP <= S_LEVEL rewritten as an unsigned sum to avoid underflow
    localparam logic [8:0] D_LIMIT = 9'(SUSTAIN_LEVEL + DECAY_STEP);

    env_state_t  st;
    logic        gate_q;
    logic        rise;
    logic        fall;
    logic [PW-1:0] pos_prod;
    logic [PW-1:0] neg_prod;
    logic [W-1:0]  pos_scaled;
    logic [W-1:0]  neg_scaled;

    assign rise  = gate & ~gate_q;
    assign fall  = ~gate & gate_q;
    assign state = st;
    assign busy  = (st != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            st     <= IDLE;
            level  <= 8'd0;
            gate_q <= 1'b0;
        end else begin
            gate_q <= gate;
            if (rise) begin
                st <= ATTACK;
            end else if (fall) begin
                if (st inside {ATTACK, DECAY, SUSTAIN})
                    st <= RELEASE;
            end else if (fs_tick) begin
                unique case (st)
                    IDLE: begin
                        level <= 8'd0;
                    end
                    ATTACK: begin
                        if (level > A_LIMIT) begin
                            level <= 8'hff;
                            st    <= DECAY;
                        end else begin
                            level <= level + A_STEP;
                        end
                    end
                    DECAY: begin
                        if ({1'b0, level} <= D_LIMIT) begin
                            level <= S_LEVEL;
                            st    <= SUSTAIN;
                        end else begin
                            level <= level - D_STEP;
                        end
                    end
                    SUSTAIN: begin
                        level <= S_LEVEL;
                    end
                    RELEASE: begin
                        if (level <= R_STEP) begin
                            level <= 8'd0;
                            st    <= IDLE;
                        end else begin
                            level <= level - R_STEP;
                        end
                    end
                    default: begin
                        level <= 8'd0;
                        st    <= IDLE;
                    end
                endcase
            end
        end
    end

    assign pos_prod   = PW'(pos_in) * PW'(level);
    assign neg_prod   = PW'(neg_in) * PW'(level);
    assign pos_scaled = W'(pos_prod >> 8);
    assign neg_scaled = W'(neg_prod >> 8);

    // full scale bypasses the >>8 so 255 is an exact pass-through
    always_ff @(posedge clk) begin
        if (reset) begin
            pos_out <= '0;
            neg_out <= '0;
        end else begin
            pos_out <= (level == 8'hff) ? pos_in : pos_scaled;
            neg_out <= (level == 8'hff) ? neg_in : neg_scaled;
        end
    end

endmodule

// File: tb/tb_envelope_shaper.sv
// Directed bench for envelope_shaper: ADSR walk, scaling,
// retrigger, coincident tick and mid-note reset.
module tb_envelope_shaper;

    localparam int W = 9;

    logic         clk;
    logic         reset;
    logic         fs_tick;
    logic         gate;
    logic [W-1:0] pos_in;
    logic [W-1:0] neg_in;
    logic [W-1:0] pos_out;
    logic [W-1:0] neg_out;
    logic [7:0]   level;
    logic [2:0]   state;
    logic         busy;

    int pass_cnt;
    int total_cnt;

    envelope_shaper #(
        .W(W),
        .ATTACK_STEP(8),
        .DECAY_STEP(2),
        .SUSTAIN_LEVEL(192),
        .RELEASE_STEP(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .fs_tick(fs_tick),
        .gate(gate),
        .pos_in(pos_in),
        .neg_in(neg_in),
        .pos_out(pos_out),
        .neg_out(neg_out),
        .level(level),
        .state(state),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic cycle(input logic tick);
        fs_tick = tick;
        @(posedge clk);
        #1;
        fs_tick = 1'b0;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        gate   = 1'b0;
        pos_in = 9'd300;
        neg_in = 9'd300;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1);
            total_cnt++;
            if (state !== 3'd0 || level !== 8'd0 || busy !== 1'b0
                || pos_out !== 9'd0 || neg_out !== 9'd0)
                $display("FAIL reset cyc%0d: st=%0d lvl=%0d busy=%b pos=%0d neg=%0d, want 0",
                         i, state, level, busy, pos_out, neg_out);
            else
                pass_cnt++;
        end
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            cycle(1'b1);
            total_cnt++;
            if (state !== 3'd0 || level !== 8'd0 || pos_out !== 9'd0)
                $display("FAIL idle_tick%0d: st=%0d lvl=%0d pos=%0d, want 0/0/0",
                         i, state, level, pos_out);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_attack();
        gate = 1'b1;
        cycle(1'b0);
        total_cnt++;
        if (state !== 3'd1 || level !== 8'd0)
            $display("FAIL attack_start: st=%0d lvl=%0d, want 1/0", state, level);
        else
            pass_cnt++;
        for (int k = 1; k <= 32; k++) begin
            cycle(1'b1);
            total_cnt++;
            if (k < 32) begin
                if (state !== 3'd1 || level !== 8'(8 * k))
                    $display("FAIL attack_tick%0d: st=%0d lvl=%0d, want 1/%0d",
                             k, state, level, 8 * k);
                else
                    pass_cnt++;
            end else begin
                if (state !== 3'd2 || level !== 8'd255)
                    $display("FAIL attack_top: st=%0d lvl=%0d, want 2/255",
                             state, level);
                else
                    pass_cnt++;
            end
            if (k == 31) begin
                pos_in = 9'd511;
                cycle(1'b0);
                total_cnt++;
                if (pos_out !== 9'd495)
                    $display("FAIL scale_248: pos_out=%0d, want 495", pos_out);
                else
                    pass_cnt++;
            end
        end
        pos_in = 9'd511;
        neg_in = 9'd256;
        cycle(1'b0);
        total_cnt++;
        if (pos_out !== 9'd511 || neg_out !== 9'd256)
            $display("FAIL scale_full: pos=%0d neg=%0d, want 511/256",
                     pos_out, neg_out);
        else
            pass_cnt++;
    endtask

    task automatic test_decay();
        for (int k = 1; k <= 32; k++) begin
            cycle(1'b1);
            total_cnt++;
            if (k < 32) begin
                if (state !== 3'd2 || level !== 8'(255 - 2 * k))
                    $display("FAIL decay_tick%0d: st=%0d lvl=%0d, want 2/%0d",
                             k, state, level, 255 - 2 * k);
                else
                    pass_cnt++;
            end else begin
                if (state !== 3'd3 || level !== 8'd192)
                    $display("FAIL decay_end: st=%0d lvl=%0d, want 3/192",
                             state, level);
                else
                    pass_cnt++;
            end
        end
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1);
            total_cnt++;
            if (state !== 3'd3 || level !== 8'd192)
                $display("FAIL sustain_hold%0d: st=%0d lvl=%0d, want 3/192",
                         i, state, level);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_scaling();
        pos_in = 9'd0;
        neg_in = 9'd0;
        cycle(1'b0);
        total_cnt++;
        if (pos_out !== 9'd0 || neg_out !== 9'd0)
            $display("FAIL scale_zero: pos=%0d neg=%0d, want 0/0", pos_out, neg_out);
        else
            pass_cnt++;
        pos_in = 9'd300;
        cycle(1'b0);
        total_cnt++;
        if (pos_out !== 9'd225 || neg_out !== 9'd0)
            $display("FAIL scale_300: pos=%0d neg=%0d, want 225/0", pos_out, neg_out);
        else
            pass_cnt++;
        neg_in = 9'd100;
        cycle(1'b0);
        total_cnt++;
        if (pos_out !== 9'd225 || neg_out !== 9'd75)
            $display("FAIL scale_neg: pos=%0d neg=%0d, want 225/75", pos_out, neg_out);
        else
            pass_cnt++;
    endtask

    task automatic test_release();
        gate = 1'b0;
        cycle(1'b1);
        total_cnt++;
        if (state !== 3'd4 || level !== 8'd192)
            $display("FAIL release_start: st=%0d lvl=%0d, want 4/192", state, level);
        else
            pass_cnt++;
        for (int k = 1; k <= 48; k++) begin
            cycle(1'b1);
            total_cnt++;
            if (k < 48) begin
                if (state !== 3'd4 || level !== 8'(192 - 4 * k))
                    $display("FAIL release_tick%0d: st=%0d lvl=%0d, want 4/%0d",
                             k, state, level, 192 - 4 * k);
                else
                    pass_cnt++;
            end else begin
                if (state !== 3'd0 || level !== 8'd0 || busy !== 1'b0)
                    $display("FAIL release_end: st=%0d lvl=%0d busy=%b, want 0/0/0",
                             state, level, busy);
                else
                    pass_cnt++;
            end
        end
    endtask

    task automatic test_retrigger();
        gate = 1'b1;
        cycle(1'b0);
        for (int k = 0; k < 13; k++)
            cycle(1'b1);
        total_cnt++;
        if (state !== 3'd1 || level !== 8'd104)
            $display("FAIL retrig_setup: st=%0d lvl=%0d, want 1/104", state, level);
        else
            pass_cnt++;
        gate = 1'b0;
        cycle(1'b0);
        cycle(1'b1);
        total_cnt++;
        if (state !== 3'd4 || level !== 8'd100 || busy !== 1'b1)
            $display("FAIL retrig_rel: st=%0d lvl=%0d busy=%b, want 4/100/1",
                     state, level, busy);
        else
            pass_cnt++;
        gate = 1'b1;
        cycle(1'b1);
        total_cnt++;
        if (state !== 3'd1 || level !== 8'd100)
            $display("FAIL retrig_rise: st=%0d lvl=%0d, want 1/100", state, level);
        else
            pass_cnt++;
        cycle(1'b1);
        total_cnt++;
        if (state !== 3'd1 || level !== 8'd108)
            $display("FAIL retrig_step: st=%0d lvl=%0d, want 1/108", state, level);
        else
            pass_cnt++;
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        cycle(1'b1);
        total_cnt++;
        if (state !== 3'd0 || level !== 8'd0 || busy !== 1'b0)
            $display("FAIL reset_mid: st=%0d lvl=%0d busy=%b, want 0/0/0",
                     state, level, busy);
        else
            pass_cnt++;
        reset = 1'b0;
        cycle(1'b1);
        total_cnt++;
        if (state !== 3'd1 || level !== 8'd0)
            $display("FAIL reset_gate_high: st=%0d lvl=%0d, want 1/0", state, level);
        else
            pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        reset     = 1'b1;
        fs_tick   = 1'b0;
        gate      = 1'b0;
        pos_in    = '0;
        neg_in    = '0;
        test_reset();
        test_attack();
        test_decay();
        test_scaling();
        test_release();
        test_retrigger();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
